// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-streamer state type.
package axi_pkg;

  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned AXI_4K_BYTES   = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/axi_interface.sv
// AXI4 bundle with master/slave modports; the read streamer drives the master side.
interface axi_interface #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi_burst_calc.sv
// Next-burst beat count: min(MAX_BURST, remaining), additionally clipped at the
// 4 KiB page boundary when AXI_READ_STREAMER_4K_SPLIT_EN is defined.
module axi_burst_calc
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int BEATS_W    = $clog2(MAX_BURST) + 1
) (
  input  logic [11:0]        i_addr_lo,
  input  logic [31:0]        i_remaining,
  output logic [BEATS_W-1:0] o_beats
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);

  logic [31:0] w_cap;

  always_comb begin
    w_cap = (i_remaining < 32'(MAX_BURST)) ? i_remaining : 32'(MAX_BURST);
  end

`ifdef AXI_READ_STREAMER_4K_SPLIT_EN
  logic [12:0] w_bytes_to_4k;
  logic [31:0] w_beats_to_4k;

  // Address is beat-aligned, so at least one full beat always fits in the page.
  always_comb begin
    w_bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, i_addr_lo};
    w_beats_to_4k = 32'(w_bytes_to_4k >> SIZE_LOG2);
    o_beats       = (w_beats_to_4k < w_cap) ? BEATS_W'(w_beats_to_4k) : BEATS_W'(w_cap);
  end
`else
  logic w_unused_addr;

  assign w_unused_addr = ^i_addr_lo;
  assign o_beats       = BEATS_W'(w_cap);
`endif

endmodule

// File: rtl/axi_read_streamer.sv
// Streams cmd_beats words from memory over AXI4 read bursts straight to out_*.
// Optional 4 KiB burst splitting: define AXI_READ_STREAMER_4K_SPLIT_EN.
module axi_read_streamer
  import axi_pkg::*;
#(
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_beats,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  error,
  axi_interface.master          to_slave
);

  localparam int SIZE_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int BEATS_W   = $clog2(MAX_BURST) + 1;
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << SIZE_LOG2;

  stream_state_e         r_state;
  stream_state_e         w_state_next;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [31:0]           r_issue_rem;
  logic [31:0]           r_out_rem;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_error;

  logic                  w_accept;
  logic                  w_arvalid;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rlast_hs;
  logic                  w_final_beat;
  logic [BEATS_W-1:0]    w_burst_beats;
  logic [ADDR_WIDTH-1:0] w_addr_incr;
  logic                  w_unused;

  axi_burst_calc #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .BEATS_W    (BEATS_W)
  ) u_burst_calc (
    .i_addr_lo   (r_araddr[11:0]),
    .i_remaining (r_issue_rem),
    .o_beats     (w_burst_beats)
  );

  assign w_accept     = cmd_valid && (r_state == ST_IDLE);
  assign w_ar_hs      = w_arvalid && to_slave.arready;
  assign w_r_hs       = to_slave.rvalid && out_ready;
  assign w_rlast_hs   = w_r_hs && to_slave.rlast;
  assign w_final_beat = (r_state != ST_IDLE) && (r_out_rem == 32'd1);
  assign w_addr_incr  = ADDR_WIDTH'(w_burst_beats) << SIZE_LOG2;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cmd_ready    = 1'b0;
    w_arvalid    = 1'b0;
    busy         = 1'b1;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (w_accept && (cmd_beats != 32'd0)) begin
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_arvalid = (r_outstanding < OUT_W'(MAX_OUTSTANDING));
        if (w_ar_hs && (r_issue_rem == 32'(w_burst_beats))) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_r_hs && w_final_beat) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        busy         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_araddr    <= '0;
      r_issue_rem <= '0;
      r_out_rem   <= '0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      r_araddr    <= cmd_addr & ALIGN_MASK;
      r_issue_rem <= cmd_beats;
      r_out_rem   <= cmd_beats;
      r_error     <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_araddr    <= r_araddr + w_addr_incr;
        r_issue_rem <= r_issue_rem - 32'(w_burst_beats);
      end
      if (w_r_hs && (r_state != ST_IDLE)) begin
        r_out_rem <= r_out_rem - 32'd1;
      end
      if (w_r_hs && (to_slave.rresp != AXI_RESP_OKAY)) begin
        r_error <= 1'b1;
      end
    end
  end

  // A burst issued and another retired in the same cycle leave the count as is.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_ar_hs, w_rlast_hs})
        2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
        2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign error     = r_error;
  assign out_valid = to_slave.rvalid;
  assign out_data  = to_slave.rdata;
  assign out_last  = to_slave.rvalid && w_final_beat;

  assign to_slave.arid     = '0;
  assign to_slave.araddr   = r_araddr;
  assign to_slave.arlen    = 8'(w_burst_beats - BEATS_W'(1));
  assign to_slave.arsize   = 3'(SIZE_LOG2);
  assign to_slave.arburst  = AXI_BURST_INCR;
  assign to_slave.arlock   = 1'b0;
  assign to_slave.arcache  = '0;
  assign to_slave.arprot   = '0;
  assign to_slave.arqos    = '0;
  assign to_slave.arregion = '0;
  assign to_slave.arvalid  = w_arvalid;
  assign to_slave.rready   = out_ready;

  // Read-only master: write channels parked.
  assign to_slave.awid     = '0;
  assign to_slave.awaddr   = '0;
  assign to_slave.awlen    = '0;
  assign to_slave.awsize   = '0;
  assign to_slave.awburst  = '0;
  assign to_slave.awlock   = 1'b0;
  assign to_slave.awcache  = '0;
  assign to_slave.awprot   = '0;
  assign to_slave.awqos    = '0;
  assign to_slave.awregion = '0;
  assign to_slave.awvalid  = 1'b0;
  assign to_slave.wdata    = '0;
  assign to_slave.wstrb    = '0;
  assign to_slave.wlast    = 1'b0;
  assign to_slave.wvalid   = 1'b0;
  assign to_slave.bready   = 1'b1;

  assign w_unused = ^{to_slave.rid, to_slave.awready, to_slave.wready,
                      to_slave.bid, to_slave.bresp, to_slave.bvalid};

endmodule

// File: doc/axi_read_streamer.md
AXI_READ_STREAMER -- requirements
Module: axi_read_streamer

Interface
REQ-001 The block SHALL have parameter ID_WIDTH, default 1, meaning AXI ID width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 64, meaning AXI address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 64, meaning AXI data and out_data width (power of two, >=8).
REQ-004 The block SHALL have parameter MAX_BURST, default 16, meaning maximum beats per AR burst (1..256, power of two).
REQ-005 The block SHALL have parameter MAX_OUTSTANDING, default 4, meaning maximum issued-but-uncompleted AR bursts.
REQ-006 The block SHALL have these ports: ap_clk  in  1  sole clock, all logic on its rising edge.
REQ-007 The block SHALL have these ports: ap_rst_n  in  1  asynchronous active-low reset.
REQ-008 The block SHALL have these ports: cmd_addr  in  ADDR_WIDTH  start byte address; cmd_beats  in  32  beat count; cmd_valid  in  1; cmd_ready  out  1.
REQ-009 The block SHALL have these ports: out_data  out  DATA_WIDTH; out_last  out  1  final beat of command; out_valid  out  1; out_ready  in  1.
REQ-010 The block SHALL have these ports: busy  out  1  command in progress; error  out  1  sticky non-OKAY response seen.
REQ-011 The block SHALL have these ports: to_slave  axi_interface.master  AXI4 read master port, intended to drive the slave side of the codebase's AXI buffer stage.

Function
REQ-012 The block SHALL accept a command on a cmd_valid && cmd_ready cycle, where cmd_ready=1 only in IDLE.
REQ-013 The block SHALL force the low log2(DATA_WIDTH/8) bits of cmd_addr to zero.
REQ-014 The block SHALL implement FSM IDLE->ISSUE on accept with cmd_beats>0, ISSUE->DRAIN when the last AR handshakes, and DRAIN->IDLE when the final R beat handshakes.
REQ-015 The block SHALL, on accepting cmd_beats=0, issue no AR, produce no out beat, stay in IDLE, and leave cmd_ready=1.
REQ-016 The block SHALL split each command into INCR bursts of min(MAX_BURST, remaining) beats, with ARLEN=beats-1, ARSIZE=log2(DATA_WIDTH/8), ARBURST=2'b01, ARID=0, and ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION=0.
REQ-017 The block SHALL hold ARVALID and all AR fields stable until ARREADY; the next AR SHALL be presented at the earliest in the cycle after the handshake.
REQ-018 The block SHALL deassert ARVALID while the outstanding count equals MAX_OUTSTANDING.
REQ-019 The block SHALL increment the outstanding count on an AR handshake and decrement it on an R handshake with RLAST=1; when both occur in the same cycle, the count SHALL be unchanged.
REQ-020 The block SHALL pass R beats through combinationally: RREADY=out_ready, out_valid=RVALID, out_data=RDATA, so an R beat reaches the output with zero added latency.
REQ-021 The block SHALL assert out_last only on the R beat that completes cmd_beats total beats, counted independently of RLAST.
REQ-022 The block SHALL set error when an R handshake carries RRESP!=2'b00, and SHALL clear it only on the next command accept.
REQ-023 The block SHALL keep busy=1 from the accept cycle (cmd_beats>0) until the cycle after the out_last handshake.
REQ-024 The block SHALL tie off the write channels: AWVALID=0, WVALID=0, BREADY=1, and all other AW/W fields 0.
REQ-025 The block SHALL treat remaining-beat and address arithmetic as unsigned; the next address SHALL be ARADDR + beats*(DATA_WIDTH/8), truncated to ADDR_WIDTH with wrap-around.

Reset
REQ-026 On ap_rst_n=0, the block SHALL immediately enter IDLE and drive cmd_ready=1, ARVALID=0, busy=0, error=0, out_last=0, outstanding=0, and counters=0.
REQ-027 On reset mid-command, the block SHALL abandon the command; the attached slave shares ap_rst_n, so no in-flight R beats are expected after reset.

Configuration
REQ-028 When AXI_READ_STREAMER_4K_SPLIT_EN is defined, the block SHALL additionally end any burst that would cross a 4096-byte boundary at that boundary.
REQ-029 When AXI_READ_STREAMER_4K_SPLIT_EN is undefined, bursts SHALL be split by MAX_BURST and remaining beats only.

Structure
REQ-030 Package axi_pkg SHALL hold the AXI_BURST_INCR, AXI_RESP_OKAY and AXI_4K_BYTES constants, and the state enum typedef.
REQ-031 Sub-module axi_burst_calc SHALL compute the next burst length from the address, the remaining beats, MAX_BURST and the 4K option.

Verification
REQ-032 Test: cmd addr=0x1000, beats=40, MAX_BURST=16 -> AR bursts ARLEN 15,15,7 at 0x1000,0x1080,0x1100, and out_last on beat 40 only.
REQ-033 Test: with the macro defined, cmd addr=0x0FC0, beats=16 -> ARLEN 7 at 0x0FC0, then ARLEN 7 at 0x1000; with the macro undefined -> a single ARLEN 15.
REQ-034 Test: ARREADY=1 and RVALID held 0, beats=160 -> exactly 4 ARs issued, ARVALID then low until the first RLAST handshake.
REQ-035 Test: beats=0 -> no ARVALID, busy stays 0, cmd_ready stays 1.
REQ-036 Test: RRESP=2'b10 on beat 3 -> error=1 through command end and cleared on the next accept; all beats still delivered.
REQ-037 Test: out_ready toggled 50% random -> RREADY mirrors it, the data order is preserved, and ap_rst_n pulsed mid-command returns all outputs to reset values.
